vram_writer: RTL
================

# vram_writer

CPU-side write port for the GPU's 200x150, 3-bit-colour video RAM; the write end of the memory the scan-out framebuffer reads. It decodes a small 6502-visible register window (cursor X/Y, colour, pixel data, command, status), converts cursor coordinates to a linear VRAM address, and drives a single-cycle VRAM write strobe. It also runs a hardware clear-screen state machine that fills all 30000 locations with one colour without CPU involvement.

## Interface
- RESOLUTION_W, 200, pixels per line
- RESOLUTION_H, 150, lines per frame
- COLOR_DEPTH, 3, bits per pixel
- ADDR_W, 15, VRAM linear address width (needs W*H ≤ 2^ADDR_W)

- PIXEL_CLOCK  in  1  sole clock; all logic rising-edge
- RESET  in  1  asynchronous, active-high; clears all state
- CPU_SEL  in  1  one-cycle access pulse, already synchronised to PIXEL_CLOCK
- CPU_WE  in  1  1 = write, 0 = read; sampled with CPU_SEL
- CPU_ADDR  in  3  register index
- CPU_DIN  in  8  write data
- CPU_DOUT  out  8  registered read data
- BUSY  out  1  clear in progress
- VRAM_ADDR  out  ADDR_W  linear address = Y*RESOLUTION_W + X
- VRAM_DATA  out  COLOR_DEPTH  pixel value
- VRAM_WE  out  1  one-cycle write strobe

## Operation
- Registers (index: name, access):
  - 0 X (R/W): write ≥ RESOLUTION_W stores RESOLUTION_W-1.
  - 1 Y (R/W): write ≥ RESOLUTION_H stores RESOLUTION_H-1.
  - 2 COLOR (R/W): bits [2:0]; reads return upper bits 0.
  - 3 PIXEL (W): writes DIN[2:0] at (X,Y), then advances cursor.
  - 4 CMD (W): 0x01 = CLEAR (fill with COLOR); other values ignored.
  - 5 STATUS (R): bit0 = BUSY, others 0.
  - 6, 7: reads return 0; writes ignored.
- Cursor advance after PIXEL: X+1; X=W-1 wraps to 0 with Y+1; (W-1,H-1) wraps to (0,0).
- Address: Y*200 computed as (Y<<7)+(Y<<6)+(Y<<3), no multiplier; result fits ADDR_W.
- States: IDLE, CLEAR.
  - IDLE→CLEAR on CMD write of 0x01; counter loaded 0, BUSY set next edge.
  - CLEAR: per cycle VRAM_WE=1, VRAM_ADDR=counter, VRAM_DATA=COLOR latched at command time; counter+1.
  - CLEAR→IDLE after writing address W*H-1 (29999); BUSY falls on the following edge.
- While BUSY: PIXEL and CMD writes dropped (no queueing, no cursor advance); X, Y, COLOR writes and all reads accepted; COLOR changes do not affect the running clear.
- Reset mid-clear aborts immediately; no resume.

## Timing
- Reset values: CPU_DOUT=0, BUSY=0, VRAM_ADDR=0, VRAM_DATA=0, VRAM_WE=0, X=Y=0, COLOR=0, state IDLE.
- Register write takes effect at the edge where CPU_SEL&&CPU_WE is sampled.
- PIXEL write: VRAM_WE high for exactly the next cycle, with the pre-advance address; cursor updated on the same edge.
- Back-to-back PIXEL writes on consecutive cycles: one VRAM write per cycle, consecutive addresses.
- Read: CPU_DOUT valid the cycle after CPU_SEL and held until the next read.
- CLEAR: first VRAM_WE the cycle after the CMD write; exactly 30000 consecutive write cycles; BUSY high for 30000 cycles.
- VRAM_WE=0 in all other cycles; VRAM_ADDR/VRAM_DATA hold their last values when WE=0.

## Test plan
- Reset, read regs 0-5 -> all 0; VRAM_WE never asserted.
- X=10, Y=10, PIXEL=0x01 -> one cycle VRAM_WE, ADDR=2010, DATA=1; X reads 11.
- X=199, Y=149, two PIXEL writes -> addresses 29999 then 0; cursor reads (1,0).
- X write 250, Y write 200 -> read back 199 and 149.
- COLOR=5, CMD=0x01 -> 30000 writes, addresses 0..29999, data 5, BUSY high 30000 cycles; PIXEL and COLOR=2 writes mid-clear -> no extra write, fill stays 5; STATUS bit0 reads 1 then 0.
- RESET at clear write 1000 -> BUSY and VRAM_WE 0 immediately; after release, PIXEL at (0,0) -> single write to address 0.

Source files
------------

// File: rtl/vram_writer.sv
// vram_writer: CPU register window plus write port into the 200x150 3-bit framebuffer.
// Latency: register writes land on the sampling edge; a PIXEL write strobes VRAM the next cycle; reads return the next cycle.
// Backpressure: none. PIXEL and CMD writes issued while a clear is running are silently dropped.
module vram_writer #(
  parameter int RESOLUTION_W = 200,
  parameter int RESOLUTION_H = 150,
  parameter int COLOR_DEPTH  = 3,
  parameter int ADDR_W       = 15
) (
  input  logic                   PIXEL_CLOCK,
  input  logic                   RESET,
  input  logic                   CPU_SEL,
  input  logic                   CPU_WE,
  input  logic [2:0]             CPU_ADDR,
  input  logic [7:0]             CPU_DIN,
  output logic [7:0]             CPU_DOUT,
  output logic                   BUSY,
  output logic [ADDR_W-1:0]      VRAM_ADDR,
  output logic [COLOR_DEPTH-1:0] VRAM_DATA,
  output logic                   VRAM_WE
);

  // Register window indices
  localparam logic [2:0] REG_X      = 3'd0;
  localparam logic [2:0] REG_Y      = 3'd1;
  localparam logic [2:0] REG_COLOR  = 3'd2;
  localparam logic [2:0] REG_PIXEL  = 3'd3;
  localparam logic [2:0] REG_CMD    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  localparam logic [7:0] CMD_CLEAR = 8'h01;

  // Largest legal cursor coordinates; out-of-range writes clamp to these
  localparam logic [7:0] X_MAX = 8'(RESOLUTION_W - 1);
  localparam logic [7:0] Y_MAX = 8'(RESOLUTION_H - 1);

  // Final linear address written by a clear
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RESOLUTION_W * RESOLUTION_H - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic [7:0]             x_q, x_d;
  logic [7:0]             y_q, y_d;
  logic [COLOR_DEPTH-1:0] color_q, color_d;
  logic [COLOR_DEPTH-1:0] fill_q, fill_d;
  logic [7:0]             dout_q, dout_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [COLOR_DEPTH-1:0] data_q, data_d;
  logic                   pix_we_q, pix_we_d;

  logic                   cpu_wr;
  logic                   cpu_rd;
  logic                   busy;
  logic [ADDR_W-1:0]      y_ext;
  logic [ADDR_W-1:0]      cursor_addr;

  assign cpu_wr = CPU_SEL & CPU_WE;
  assign cpu_rd = CPU_SEL & ~CPU_WE;
  assign busy   = (state_q == ST_CLEAR);

  // Y*200 as a sum of shifts (128+64+8); this decomposition is tied to a 200-pixel line
  assign y_ext       = ADDR_W'(y_q);
  assign cursor_addr = (y_ext << 7) + (y_ext << 6) + (y_ext << 3) + ADDR_W'(x_q);

  // Next-state: register window decode, cursor advance and the clear sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    fill_d   = fill_q;
    dout_d   = dout_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pix_we_d = 1'b0;

    if (cpu_wr) begin
      case (CPU_ADDR)
        REG_X:     x_d = (CPU_DIN > X_MAX) ? X_MAX : CPU_DIN;
        REG_Y:     y_d = (CPU_DIN > Y_MAX) ? Y_MAX : CPU_DIN;
        REG_COLOR: color_d = CPU_DIN[COLOR_DEPTH-1:0];
        REG_PIXEL: begin
          if (!busy) begin
            pix_we_d = 1'b1;
            addr_d   = cursor_addr;
            data_d   = CPU_DIN[COLOR_DEPTH-1:0];
            if (x_q == X_MAX) begin
              x_d = 8'd0;
              y_d = (y_q == Y_MAX) ? 8'd0 : y_q + 8'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        end
        REG_CMD: begin
          if (!busy && CPU_DIN == CMD_CLEAR) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            fill_d  = color_q;
          end
        end
        default: ;
      endcase
    end

    if (cpu_rd) begin
      case (CPU_ADDR)
        REG_X:      dout_d = x_q;
        REG_Y:      dout_d = y_q;
        REG_COLOR:  dout_d = 8'(color_q);
        REG_STATUS: dout_d = {7'd0, busy};
        default:    dout_d = 8'd0;
      endcase
    end

    // The clear drives VRAM straight from the counter; mirror it into the
    // pixel-path registers so the outputs hold the last cleared location afterwards.
    if (state_q == ST_CLEAR) begin
      addr_d = cnt_q;
      data_d = fill_q;
      cnt_d  = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State and register bank; reset aborts any clear in progress
  always_ff @(posedge PIXEL_CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      color_q  <= '0;
      fill_q   <= '0;
      dout_q   <= 8'd0;
      addr_q   <= '0;
      data_q   <= '0;
      pix_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      fill_q   <= fill_d;
      dout_q   <= dout_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pix_we_q <= pix_we_d;
    end
  end

  assign CPU_DOUT  = dout_q;
  assign BUSY      = busy;
  assign VRAM_WE   = busy | pix_we_q;
  assign VRAM_ADDR = busy ? cnt_q  : addr_q;
  assign VRAM_DATA = busy ? fill_q : data_q;

endmodule
